configurador_sccb_ov7670: RTL and testbench

- Transmit side of the OV7670 camera link: an SCCB (I2C-like) write-only master.
- After `iniciar`, it plays a fixed register table into the sensor so the capture path receives the expected pixel format (QVGA, RGB565).
- Sits beside the capture datapath in the camera top level. The top level turns `siod_o`/`siod_oe` into the tri-state SIOD pad.

---
 rtl/configurador_sccb_ov7670_if.sv | 31 +++
 rtl/configurador_sccb_ov7670.sv | 249 ++++++++++++++++++++++++
 tb/tb_configurador_sccb_ov7670.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/configurador_sccb_ov7670_if.sv
// Start/status handshake and SCCB pin bundle between the OV7670 configurator and the camera top level.
// The master modport belongs to the configurator. The slave modport belongs to whoever starts it and owns the pads.
interface configurador_sccb_ov7670_if;
    logic       iniciar;
    logic       sioc;
    logic       siod_o;
    logic       siod_oe;
    logic       ocupado;
    logic       pronto;
    logic [2:0] indice_registro;

    modport master (
        input  iniciar,
        output sioc,
        output siod_o,
        output siod_oe,
        output ocupado,
        output pronto,
        output indice_registro
    );

    modport slave (
        output iniciar,
        input  sioc,
        input  siod_o,
        input  siod_oe,
        input  ocupado,
        input  pronto,
        input  indice_registro
    );
endinterface

// File: rtl/configurador_sccb_ov7670.sv
// Purpose: write-only SCCB master that plays the fixed OV7670 register table (QVGA, RGB565) after iniciar.
// Latency: outputs are registered; a full table takes 600*DIV_Q + DELAY_RESET cycles plus one DONE cycle.
// Backpressure: none; iniciar is sampled only in IDLE, the sensor ACK is ignored and the bus is never stretched.
module configurador_sccb_ov7670 #(
    parameter int         DIV_Q       = 125,
    parameter int         DELAY_RESET = 50000,
    parameter logic [7:0] ID_ESCRITA  = 8'h42
) (
    input  logic                           clock,
    input  logic                           reset,
    configurador_sccb_ov7670_if.master     bus
);

    localparam int QW = $clog2(DIV_Q);
    localparam int DW = (DELAY_RESET > 1) ? $clog2(DELAY_RESET) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_GAP,
        ST_DELAY,
        ST_DONE
    } estado_t;

    estado_t         estado,    estado_nx;
    logic [1:0]      quarto,    quarto_nx;
    logic [QW-1:0]   cnt_q,     cnt_q_nx;
    logic [1:0]      byte_sel,  byte_sel_nx;
    logic [3:0]      bit_sel,   bit_sel_nx;
    logic [2:0]      indice,    indice_nx;
    logic [DW-1:0]   cnt_dly,   cnt_dly_nx;

    logic            sioc_r,    sioc_nx;
    logic            siod_r,    siod_nx;
    logic            oe_r,      oe_nx;
    logic            ocupado_r, ocupado_nx;
    logic            pronto_r,  pronto_nx;
    logic [2:0]      idx_out_r, idx_out_nx;

    logic            fim_quarto;
    logic [7:0]      byte_atual;
    logic            bit_atual;

    function automatic logic [7:0] tabela_reg(input logic [2:0] i);
        case (i)
            3'd0:    tabela_reg = 8'h12;
            3'd1:    tabela_reg = 8'h12;
            3'd2:    tabela_reg = 8'h40;
            3'd3:    tabela_reg = 8'h8C;
            3'd4:    tabela_reg = 8'h11;
            default: tabela_reg = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] tabela_dado(input logic [2:0] i);
        case (i)
            3'd0:    tabela_dado = 8'h80;
            3'd1:    tabela_dado = 8'h14;
            3'd2:    tabela_dado = 8'hD0;
            3'd3:    tabela_dado = 8'h00;
            3'd4:    tabela_dado = 8'h01;
            default: tabela_dado = 8'h00;
        endcase
    endfunction

    assign fim_quarto = (cnt_q == QW'(DIV_Q - 1));

    // Sequencing: every bus phase is built from quarters of DIV_Q cycles, four per step.
    always_comb begin
        estado_nx   = estado;
        quarto_nx   = quarto;
        cnt_q_nx    = cnt_q;
        byte_sel_nx = byte_sel;
        bit_sel_nx  = bit_sel;
        indice_nx   = indice;
        cnt_dly_nx  = cnt_dly;

        case (estado)
            ST_IDLE: begin
                if (bus.iniciar) begin
                    estado_nx = ST_START;
                    indice_nx = 3'd0;
                    cnt_q_nx  = '0;
                    quarto_nx = 2'd0;
                end
            end

            ST_START, ST_BIT, ST_STOP, ST_GAP: begin
                if (!fim_quarto) begin
                    cnt_q_nx = cnt_q + QW'(1);
                end else begin
                    cnt_q_nx  = '0;
                    quarto_nx = quarto + 2'd1;
                    if (quarto == 2'd3) begin
                        if (estado == ST_START) begin
                            estado_nx   = ST_BIT;
                            byte_sel_nx = 2'd0;
                            bit_sel_nx  = 4'd0;
                        end else if (estado == ST_BIT) begin
                            if (bit_sel == 4'd8) begin
                                bit_sel_nx = 4'd0;
                                if (byte_sel == 2'd2) begin
                                    estado_nx = ST_STOP;
                                end else begin
                                    byte_sel_nx = byte_sel + 2'd1;
                                end
                            end else begin
                                bit_sel_nx = bit_sel + 4'd1;
                            end
                        end else if (estado == ST_STOP) begin
                            estado_nx = ST_GAP;
                        end else begin
                            // Entry 0 soft-resets the sensor, which needs settling time before the next write.
                            if (indice == 3'd0) begin
                                if (DELAY_RESET == 0) begin
                                    estado_nx = ST_START;
                                    indice_nx = 3'd1;
                                end else begin
                                    estado_nx  = ST_DELAY;
                                    cnt_dly_nx = '0;
                                end
                            end else if (indice == 3'd4) begin
                                estado_nx = ST_DONE;
                            end else begin
                                estado_nx = ST_START;
                                indice_nx = indice + 3'd1;
                            end
                        end
                    end
                end
            end

            ST_DELAY: begin
                if (cnt_dly == DW'(DELAY_RESET - 1)) begin
                    estado_nx = ST_START;
                    indice_nx = 3'd1;
                    cnt_q_nx  = '0;
                    quarto_nx = 2'd0;
                end else begin
                    cnt_dly_nx = cnt_dly + DW'(1);
                end
            end

            ST_DONE: begin
                estado_nx = ST_IDLE;
                indice_nx = 3'd0;
            end

            default: begin
                estado_nx = ST_IDLE;
                indice_nx = 3'd0;
            end
        endcase
    end

    always_comb begin
        case (byte_sel_nx)
            2'd0:    byte_atual = ID_ESCRITA;
            2'd1:    byte_atual = tabela_reg(indice_nx);
            default: byte_atual = tabela_dado(indice_nx);
        endcase
    end

    assign bit_atual = (bit_sel_nx < 4'd8) ? byte_atual[3'd7 - bit_sel_nx[2:0]] : 1'b1;

    // Pin levels are decoded from the next state so the registered outputs line up with the state registers.
    always_comb begin
        sioc_nx    = 1'b1;
        siod_nx    = 1'b1;
        oe_nx      = 1'b1;
        ocupado_nx = 1'b0;
        pronto_nx  = 1'b0;
        idx_out_nx = 3'd0;

        case (estado_nx)
            ST_START: begin
                sioc_nx    = (quarto_nx != 2'd3);
                siod_nx    = (quarto_nx == 2'd0);
                ocupado_nx = 1'b1;
                idx_out_nx = indice_nx;
            end
            ST_BIT: begin
                sioc_nx    = quarto_nx[1];
                siod_nx    = bit_atual;
                oe_nx      = (bit_sel_nx != 4'd8);
                ocupado_nx = 1'b1;
                idx_out_nx = indice_nx;
            end
            ST_STOP: begin
                sioc_nx    = (quarto_nx != 2'd0);
                siod_nx    = (quarto_nx == 2'd3);
                ocupado_nx = 1'b1;
                idx_out_nx = indice_nx;
            end
            ST_GAP, ST_DELAY: begin
                ocupado_nx = 1'b1;
                idx_out_nx = indice_nx;
            end
            ST_DONE: begin
                pronto_nx = 1'b1;
            end
            default: begin
                sioc_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= ST_IDLE;
            quarto    <= 2'd0;
            cnt_q     <= '0;
            byte_sel  <= 2'd0;
            bit_sel   <= 4'd0;
            indice    <= 3'd0;
            cnt_dly   <= '0;
            sioc_r    <= 1'b1;
            siod_r    <= 1'b1;
            oe_r      <= 1'b1;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b0;
            idx_out_r <= 3'd0;
        end else begin
            estado    <= estado_nx;
            quarto    <= quarto_nx;
            cnt_q     <= cnt_q_nx;
            byte_sel  <= byte_sel_nx;
            bit_sel   <= bit_sel_nx;
            indice    <= indice_nx;
            cnt_dly   <= cnt_dly_nx;
            sioc_r    <= sioc_nx;
            siod_r    <= siod_nx;
            oe_r      <= oe_nx;
            ocupado_r <= ocupado_nx;
            pronto_r  <= pronto_nx;
            idx_out_r <= idx_out_nx;
        end
    end

    assign bus.sioc            = sioc_r;
    assign bus.siod_o          = siod_r;
    assign bus.siod_oe         = oe_r;
    assign bus.ocupado         = ocupado_r;
    assign bus.pronto          = pronto_r;
    assign bus.indice_registro = idx_out_r;

endmodule

// File: tb/tb_configurador_sccb_ov7670.sv
// Bench for the OV7670 SCCB configurator: decodes the SIOC/SIOD pins into transactions
// and compares them with the register table, frame timing and start/busy/reset rules.
module tb_configurador_sccb_ov7670;

    localparam int DQ  = 2;
    localparam int DLY = 10;
    localparam int FULL_CYCLES = 5 * 120 * DQ + DLY;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    configurador_sccb_ov7670_if bus ();

    configurador_sccb_ov7670 #(
        .DIV_Q       (DQ),
        .DELAY_RESET (DLY),
        .ID_ESCRITA  (8'h42)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    int checks   = 0;
    int failures = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] ref_reg [5] = '{8'h12, 8'h12, 8'h40, 8'h8C, 8'h11};
    logic [7:0] ref_dat [5] = '{8'h80, 8'h14, 8'hD0, 8'h00, 8'h01};

    typedef struct {
        logic [23:0] bytes;
        int          nbits;
        bit          oe_ok;
        int          gap;
        bit          idle_ok;
        logic [2:0]  idx;
    } txn_t;

    txn_t        txn_q[$];
    txn_t        cur;
    logic        p_sioc = 1'b1, p_siod = 1'b1, p_ocup = 1'b0;
    bit          in_frame = 0, after_stop = 0, idle_ok_r = 1;
    int          nbits_r = 0, stop_cyc = 0, seq_starts = 0;
    logic [23:0] sh = '0;

    // Pin-level SCCB decoder; the stop condition's own SIOC rise makes 28 edges per frame.
    always @(negedge clock) begin
        if (reset) begin
            in_frame   = 0;
            after_stop = 0;
        end else begin
            if (p_sioc && bus.sioc && p_siod && !bus.siod_o && bus.siod_oe) begin
                in_frame    = 1;
                nbits_r     = 0;
                sh          = '0;
                cur.oe_ok   = 1;
                cur.idx     = bus.indice_registro;
                cur.gap     = after_stop ? (cyc - stop_cyc) : -1;
                cur.idle_ok = idle_ok_r;
                after_stop  = 0;
            end else if (in_frame && p_sioc && bus.sioc && !p_siod && bus.siod_o && bus.siod_oe) begin
                cur.bytes  = sh;
                cur.nbits  = nbits_r;
                txn_q.push_back(cur);
                in_frame   = 0;
                after_stop = 1;
                stop_cyc   = cyc;
                idle_ok_r  = 1;
            end else if (in_frame && !p_sioc && bus.sioc) begin
                nbits_r++;
                if (nbits_r <= 27) begin
                    if (nbits_r % 9 == 0) begin
                        if (bus.siod_oe) cur.oe_ok = 0;
                    end else begin
                        sh = {sh[22:0], bus.siod_o};
                        if (!bus.siod_oe) cur.oe_ok = 0;
                    end
                end
            end
            if (after_stop && !(bus.sioc && bus.siod_o && bus.siod_oe)) idle_ok_r = 0;
        end
        if (bus.ocupado && !p_ocup) seq_starts++;
        p_ocup = bus.ocupado;
        p_sioc = bus.sioc;
        p_siod = bus.siod_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic launch(output int acc);
        bus.iniciar = 1'b1;
        tick(1);
        acc = cyc;
        bus.iniciar = 1'b0;
    endtask

    task automatic wait_pronto(input string tag, output int at);
        int n = 0;
        while (!bus.pronto && n < 5000) begin
            tick(1);
            n++;
        end
        chk_val(tag, 32'(bus.pronto), 32'd1);
        at = cyc;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_val({tag, "_sioc"},    32'(bus.sioc),            32'd1);
        chk_val({tag, "_siod_o"},  32'(bus.siod_o),          32'd1);
        chk_val({tag, "_siod_oe"}, 32'(bus.siod_oe),         32'd1);
        chk_val({tag, "_ocupado"}, 32'(bus.ocupado),         32'd0);
        chk_val({tag, "_pronto"},  32'(bus.pronto),          32'd0);
        chk_val({tag, "_indice"},  32'(bus.indice_registro), 32'd0);
    endtask

    // Transactions repeat the table in order; writes after the soft reset wait DLY extra idle cycles.
    task automatic chk_txns(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int e = i % 5;
            if (base + i < txn_q.size()) begin
                txn_t t = txn_q[base + i];
                chk_val($sformatf("%s_bytes%0d", tag, i), 32'(t.bytes), {8'h00, 8'h42, ref_reg[e], ref_dat[e]});
                chk_val($sformatf("%s_edges%0d", tag, i), 32'(t.nbits), 32'd28);
                chk_val($sformatf("%s_oe%0d", tag, i),    32'(t.oe_ok), 32'd1);
                chk_val($sformatf("%s_idx%0d", tag, i),   32'(t.idx),   32'(e));
                if (e != 0) begin
                    chk_val($sformatf("%s_gap%0d", tag, i),  32'(t.gap),     32'(6 * DQ + ((e == 1) ? DLY : 0)));
                    chk_val($sformatf("%s_idle%0d", tag, i), 32'(t.idle_ok), 32'd1);
                end
            end
        end
    endtask

    initial begin
        int t0, t1, base, s0, n;
        reset       = 1'b1;
        bus.iniciar = 1'b0;

        repeat (3) begin
            bus.iniciar = 1'($urandom_range(0, 1));
            tick(1);
        end
        chk_idle_outputs("reset");
        reset       = 1'b0;
        bus.iniciar = 1'b0;
        tick($urandom_range(2, 9));
        chk_val("idle_ocupado", 32'(bus.ocupado), 32'd0);

        // Single full table.
        launch(t0);
        chk_val("start_ocupado", 32'(bus.ocupado), 32'd1);
        chk_val("start_indice",  32'(bus.indice_registro), 32'd0);
        wait_pronto("p1_pronto_seen", t1);
        chk_val("p1_duration", 32'(t1 - t0), 32'(FULL_CYCLES));
        chk_val("p1_done_ocupado", 32'(bus.ocupado), 32'd0);
        chk_val("p1_done_indice",  32'(bus.indice_registro), 32'd0);
        tick(1);
        chk_val("p1_pronto_width", 32'(bus.pronto), 32'd0);
        chk_val("p1_txn_count", 32'(txn_q.size()), 32'd5);
        chk_txns("p1", 0, 5);

        // Busy start: iniciar during entry 2, then held through DONE.
        tick($urandom_range(1, 30));
        base = txn_q.size();
        s0   = seq_starts;
        launch(t0);
        n = 0;
        while (bus.indice_registro != 3'd2 && n < 5000) begin
            tick(1);
            n++;
        end
        chk_val("p2_reach_idx2", 32'(bus.indice_registro), 32'd2);
        tick($urandom_range(0, 100));
        bus.iniciar = 1'b1;
        wait_pronto("p2_pronto_seen", t1);
        chk_val("p2_duration", 32'(t1 - t0), 32'(FULL_CYCLES));
        chk_val("p2_done_ocupado", 32'(bus.ocupado), 32'd0);
        tick(1);
        chk_val("p2_idle_ocupado", 32'(bus.ocupado), 32'd0);
        tick(1);
        chk_val("p2_restart_ocupado", 32'(bus.ocupado), 32'd1);
        chk_val("p2_restart_indice",  32'(bus.indice_registro), 32'd0);
        t0 = cyc;
        tick($urandom_range(1, 20));
        bus.iniciar = 1'b0;
        wait_pronto("p2b_pronto_seen", t1);
        chk_val("p2b_duration", 32'(t1 - t0), 32'(FULL_CYCLES));
        tick(50);
        chk_val("p2_after_ocupado", 32'(bus.ocupado), 32'd0);
        chk_val("p2_seq_count", 32'(seq_starts - s0), 32'd2);
        chk_val("p2_txn_count", 32'(txn_q.size() - base), 32'd10);
        chk_txns("p2", base, 10);

        // Reset in slot 5 of the register byte of entry 3.
        launch(t0);
        n = 0;
        while (!(bus.indice_registro == 3'd3 && in_frame && nbits_r == 13 && !bus.sioc) && n < 5000) begin
            tick(1);
            n++;
        end
        chk_val("p3_reach_slot", 32'(nbits_r), 32'd13);
        reset       = 1'b1;
        bus.iniciar = 1'($urandom_range(0, 1));
        tick(1);
        chk_idle_outputs("midreset");
        tick(1);
        chk_val("midreset_iniciar_ignored", 32'(bus.ocupado), 32'd0);
        reset       = 1'b0;
        bus.iniciar = 1'b0;
        tick($urandom_range(1, 10));
        chk_val("p3_idle_ocupado", 32'(bus.ocupado), 32'd0);
        base = txn_q.size();
        launch(t0);
        chk_val("p3_restart_indice", 32'(bus.indice_registro), 32'd0);
        wait_pronto("p3_pronto_seen", t1);
        chk_val("p3_duration", 32'(t1 - t0), 32'(FULL_CYCLES));
        chk_val("p3_txn_count", 32'(txn_q.size() - base), 32'd5);
        chk_txns("p3", base, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
